can_frame_encoder: RTL and testbench

Serializing CAN 2.0 transmitter: the transmit-side counterpart of the frame decoder. It latches a frame descriptor (base/extended ID, RTR, DLC, up to 8 data bytes) and drives it bit by bit onto TX, one bit per SP strobe. While transmitting it generates CRC-15 and inserts stuff bits, and it monitors RX for arbitration loss and for the ACK slot. It sits between the controller's transmit request logic and the bus transceiver, sharing the bit-timing SP strobe with the receive path.

---
 rtl/can_frame_encoder_pkg.sv | 31 +++
 rtl/can_crc15_ser.sv | 31 +++
 rtl/can_frame_encoder.sv | 189 ++++++++++++++++++
 tb/tb_can_frame_encoder.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/can_frame_encoder_pkg.sv
// Shared CAN definitions for the transmit and receive paths.
// Frame field states, the CRC-15 polynomial, stuffing and fixed-field lengths.
package can_frame_encoder_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SOF,
    S_ARB,
    S_CTRL,
    S_DATA,
    S_CRC,
    S_CRC_D,
    S_ACK_S,
    S_ACK_D,
    S_EOF,
    S_IFS
  } tx_state_e;

  localparam logic [14:0] CRC15_POLY  = 15'h4599;
  localparam logic [2:0]  STUFF_LIMIT = 3'd5;
  localparam logic [6:0]  EOF_LEN     = 7'd7;
  localparam logic [6:0]  IFS_LEN     = 7'd3;

  // Index of the last data bit for a given DLC (codes 9..15 carry 8 bytes).
  function automatic logic [6:0] data_last(input logic [3:0] dlc);
    logic [3:0] n_bytes;
    n_bytes = dlc[3] ? 4'd8 : dlc;
    return {n_bytes, 3'b000} - 7'd1;
  endfunction

endpackage

// File: rtl/can_crc15_ser.sv
// Serial CRC-15 (CAN polynomial), one bit per enable, synchronous clear.
module can_crc15_ser
  import can_frame_encoder_pkg::*;
(
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic        i_bit,
  output logic [14:0] o_crc
);

  logic [14:0] r_crc;
  logic        w_fb;

  assign w_fb  = i_bit ^ r_crc[14];
  assign o_crc = r_crc;

  // Shift in one frame bit, folding in the polynomial when the feedback is set.
  // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_crc <= '0;
    end else if (i_clr) begin
      r_crc <= '0;
    end else if (i_en) begin
      r_crc <= {r_crc[13:0], 1'b0} ^ (w_fb ? CRC15_POLY : 15'h0000);
    end
  end

endmodule

// File: rtl/can_frame_encoder.sv
// CAN 2.0 frame serializer: latches a descriptor, emits one bit per SP strobe
// with CRC-15 and bit stuffing, checks the ACK slot.
// Build option: CAN_TX_ARB_MON_EN enables RX monitoring and arbitration loss in ARB.
module can_frame_encoder
  import can_frame_encoder_pkg::*;
(
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_sp,
  input  logic        i_rx,
  input  logic        i_start,
  input  logic        i_rtr,
  input  logic        i_ide,
  input  logic [10:0] i_idf,
  input  logic [17:0] i_idf_ex,
  input  logic [3:0]  i_dlc,
  input  logic [63:0] i_data,
  output logic        o_tx,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_arb_lost,
  output logic        o_ack_err
);

  // Latched frame descriptor
  logic [10:0] r_id;
  logic [17:0] r_id_ex;
  logic        r_ide, r_rtr;
  logic [3:0]  r_dlc;
  logic [63:0] r_data;

  // Field position of the bit on TX, or of the pending field bit while a stuff bit is out
  tx_state_e   r_state;
  logic [6:0]  r_cnt;
  logic [2:0]  r_run;
  logic        r_stuff_now;
  logic        r_tx, r_busy, r_done, r_arb_lost, r_ack_err;

  tx_state_e   w_adv_state, w_ld_state;
  logic [6:0]  w_adv_cnt, w_ld_cnt, w_last;
  logic        w_ld_bit, w_has_data, w_do_stuff, w_arb_lose;
  logic        w_start_acc, w_sof_load, w_bit_load, w_crc_en, w_crc_bit;
  logic [14:0] w_crc;

  assign w_has_data  = !r_rtr && (r_dlc != 4'd0);
  assign w_start_acc = i_start && (r_state == S_IDLE) && !r_busy;
  assign w_sof_load  = (r_state == S_IDLE) && r_busy && i_sp;
  assign w_do_stuff  = !r_stuff_now && (r_run == STUFF_LIMIT) &&
                       (r_state inside {S_SOF, S_ARB, S_CTRL, S_DATA, S_CRC});

`ifdef CAN_TX_ARB_MON_EN
  assign w_arb_lose  = (r_state == S_ARB) && r_tx && !i_rx;
`else
  assign w_arb_lose  = 1'b0;
`endif

  assign w_bit_load  = (r_state != S_IDLE) && i_sp && !w_arb_lose && !w_do_stuff;
  assign w_ld_state  = r_stuff_now ? r_state : w_adv_state;
  assign w_ld_cnt    = r_stuff_now ? r_cnt : w_adv_cnt;
  assign w_crc_en    = w_sof_load ||
                       (w_bit_load && (w_ld_state inside {S_ARB, S_CTRL, S_DATA}));
  assign w_crc_bit   = w_sof_load ? 1'b0 : w_ld_bit;

  // Last bit index of the field currently being sent.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_last = 7'd0;
    case (r_state)
      S_ARB:   w_last = r_ide ? 7'd31 : 7'd11;
      S_CTRL:  w_last = 7'd5;
      S_DATA:  w_last = data_last(r_dlc);
      S_CRC:   w_last = 7'd14;
      S_EOF:   w_last = EOF_LEN - 7'd1;
      S_IFS:   w_last = IFS_LEN - 7'd1;
      default: w_last = 7'd0;
    endcase
  end

  // Field position following the bit currently on TX.
  always_comb begin
    w_adv_state = r_state;
    w_adv_cnt   = r_cnt + 7'd1;
    if (r_cnt == w_last) begin
      w_adv_cnt = 7'd0;
      case (r_state)
        S_SOF:   w_adv_state = S_ARB;
        S_ARB:   w_adv_state = S_CTRL;
        S_CTRL:  w_adv_state = w_has_data ? S_DATA : S_CRC;
        S_DATA:  w_adv_state = S_CRC;
        S_CRC:   w_adv_state = S_CRC_D;
        S_CRC_D: w_adv_state = S_ACK_S;
        S_ACK_S: w_adv_state = S_ACK_D;
        S_ACK_D: w_adv_state = S_EOF;
        S_EOF:   w_adv_state = S_IFS;
        default: w_adv_state = S_IDLE;
      endcase
    end
  end

  // Bus level of the field bit at the load position.
  always_comb begin
    w_ld_bit = 1'b1;
    case (w_ld_state)
      S_SOF: w_ld_bit = 1'b0;
      S_ARB: begin
        if (w_ld_cnt <= 7'd10)      w_ld_bit = r_id[4'd10 - w_ld_cnt[3:0]];
        else if (w_ld_cnt == 7'd11) w_ld_bit = r_ide ? 1'b1 : r_rtr;   // SRR or RTR
        else if (w_ld_cnt == 7'd12) w_ld_bit = 1'b1;                   // IDE
        else if (w_ld_cnt <= 7'd30) w_ld_bit = r_id_ex[5'd30 - w_ld_cnt[4:0]];
        else                        w_ld_bit = r_rtr;
      end
      S_CTRL:  w_ld_bit = (w_ld_cnt >= 7'd2) ? r_dlc[2'd1 - w_ld_cnt[1:0]] : 1'b0;
      S_DATA:  w_ld_bit = r_data[6'd63 - w_ld_cnt[5:0]];
      S_CRC:   w_ld_bit = w_crc[4'd14 - w_ld_cnt[3:0]];
      default: w_ld_bit = 1'b1;
    endcase
  end

  can_crc15_ser u_crc (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_clr     (w_start_acc),
    .i_en      (w_crc_en),
    .i_bit     (w_crc_bit),
    .o_crc     (w_crc)
  );

  // Frame sequencer: accept a request, then on each SP check RX and load the next bit.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_id <= '0; r_id_ex <= '0; r_ide <= 1'b0; r_rtr <= 1'b0;
      r_dlc <= '0; r_data <= '0;
      r_state <= S_IDLE; r_cnt <= '0; r_run <= '0; r_stuff_now <= 1'b0;
      r_tx <= 1'b1; r_busy <= 1'b0; r_done <= 1'b0;
      r_arb_lost <= 1'b0; r_ack_err <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_arb_lost <= 1'b0;
      if (w_start_acc) begin
        r_id <= i_idf; r_id_ex <= i_idf_ex; r_ide <= i_ide; r_rtr <= i_rtr;
        r_dlc <= i_dlc; r_data <= i_data;
        r_busy    <= 1'b1;
        r_ack_err <= 1'b0;
      end else if (w_sof_load) begin
        r_tx        <= 1'b0;
        r_state     <= S_SOF;
        r_cnt       <= '0;
        r_run       <= 3'd1;
        r_stuff_now <= 1'b0;
      end else if (i_sp && (r_state != S_IDLE)) begin
        if (w_arb_lose) begin
          r_tx        <= 1'b1;
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_arb_lost  <= 1'b1;
          r_stuff_now <= 1'b0;
        end else begin
          if ((r_state == S_ACK_S) && i_rx) r_ack_err <= 1'b1;
          if (!r_stuff_now) begin
            r_state <= w_adv_state;
            r_cnt   <= w_adv_cnt;
          end
          if (w_do_stuff) begin
            r_tx        <= ~r_tx;
            r_run       <= 3'd1;
            r_stuff_now <= 1'b1;
          end else begin
            r_stuff_now <= 1'b0;
            if (w_ld_state == S_IDLE) begin
              r_tx   <= 1'b1;
              r_busy <= 1'b0;
              r_done <= 1'b1;
            end else begin
              r_tx  <= w_ld_bit;
              r_run <= (w_ld_bit == r_tx) ? r_run + 3'd1 : 3'd1;
            end
          end
        end
      end
    end
  end

  assign o_tx       = r_tx;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_arb_lost = r_arb_lost;
  assign o_ack_err  = r_ack_err;

endmodule

// File: tb/tb_can_frame_encoder.sv
// Self-checking bench for can_frame_encoder: a queue-based frame model builds the
// expected bus stream (fields, CRC, stuffing, fixed tail) and the observed TX is compared.
module tb_can_frame_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sp = 1'b0, rx = 1'b1, start = 1'b0;
  logic        rtr = 1'b0, ide = 1'b0;
  logic [10:0] idf = '0;
  logic [17:0] idf_ex = '0;
  logic [3:0]  dlc = '0;
  logic [63:0] data = '0;
  logic        tx, busy, done, arb_lost, ack_err;

  int tests_run = 0;
  int tests_failed = 0;

  bit       exp_q[$];
  bit       unst_q[$];
  bit       obs_q[$];
  bit       dq[$];
  int       exp_ack_idx;
  int       exp_stuffs;
  bit [14:0] exp_crc;

  always #5 clk = ~clk;

  can_frame_encoder dut (
    .i_clock    (clk),
    .i_reset_n  (rst_n),
    .i_sp       (sp),
    .i_rx       (rx),
    .i_start    (start),
    .i_rtr      (rtr),
    .i_ide      (ide),
    .i_idf      (idf),
    .i_idf_ex   (idf_ex),
    .i_dlc      (dlc),
    .i_data     (data),
    .o_tx       (tx),
    .o_busy     (busy),
    .o_done     (done),
    .o_arb_lost (arb_lost),
    .o_ack_err  (ack_err)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Reference model: unstuffed field list, arithmetic CRC, forward stuffing, fixed tail.
  task automatic build_model(input bit m_ide, input bit m_rtr, input bit [10:0] m_id,
                             input bit [17:0] m_idex, input bit [3:0] m_dlc,
                             input bit [63:0] m_data);
    bit body[$];
    int nbytes, crc, run;
    bit last, nxt;
    body.push_back(1'b0);
    for (int i = 10; i >= 0; i--) body.push_back(m_id[i]);
    if (m_ide) begin
      body.push_back(1'b1);
      body.push_back(1'b1);
      for (int i = 17; i >= 0; i--) body.push_back(m_idex[i]);
    end
    body.push_back(m_rtr);
    body.push_back(1'b0);
    body.push_back(1'b0);
    for (int i = 3; i >= 0; i--) body.push_back(m_dlc[i]);
    nbytes = m_rtr ? 0 : ((m_dlc > 8) ? 8 : int'(m_dlc));
    for (int i = 0; i < nbytes * 8; i++) body.push_back(m_data[63 - i]);
    crc = 0;
    for (int i = 0; i < body.size(); i++) begin
      nxt = body[i] ^ crc[14];
      crc = (crc << 1) & 32'h7fff;
      if (nxt) crc = crc ^ 32'h4599;
    end
    exp_crc = crc[14:0];
    for (int i = 14; i >= 0; i--) body.push_back(exp_crc[i]);
    unst_q = body;
    exp_q.delete();
    exp_stuffs = 0;
    run = 0;
    last = 1'b0;
    for (int i = 0; i < body.size(); i++) begin
      exp_q.push_back(body[i]);
      if (run > 0 && body[i] == last) run++;
      else run = 1;
      last = body[i];
      if (run == 5) begin
        exp_q.push_back(!last);
        last = !last;
        run = 1;
        exp_stuffs++;
      end
    end
    exp_q.push_back(1'b1);            // CRC delimiter
    exp_ack_idx = exp_q.size();
    exp_q.push_back(1'b1);            // ACK slot (driven recessive)
    exp_q.push_back(1'b1);            // ACK delimiter
    for (int i = 0; i < 10; i++) exp_q.push_back(1'b1);  // EOF + IFS
  endtask

  // Receiver-style destuffing of the observed stream.
  task automatic destuff(input int n);
    int run;
    bit last, b;
    dq.delete();
    run = 0;
    last = 1'b0;
    for (int i = 0; i < obs_q.size() && dq.size() < n; i++) begin
      b = obs_q[i];
      if (run == 5) begin
        run = 1;
        last = b;
      end else begin
        if (run > 0 && b == last) run++;
        else run = 1;
        last = b;
        dq.push_back(b);
      end
    end
  endtask

  task automatic launch(input bit l_ide, input bit l_rtr, input bit [10:0] l_id,
                        input bit [17:0] l_idex, input bit [3:0] l_dlc,
                        input bit [63:0] l_data);
    @(negedge clk);
    ide = l_ide; rtr = l_rtr; idf = l_id; idf_ex = l_idex; dlc = l_dlc; data = l_data;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL launch_busy: busy=%b expected 1", busy);
    end
  endtask

  // Issue SP strobes until done/arb_lost, looping RX to TX except at SP number force_j.
  task automatic run_stream(input int force_j, input bit force_val,
                            output int n_done, output int n_arb);
    bit fin;
    obs_q.delete();
    n_done = 0;
    n_arb = 0;
    fin = 1'b0;
    for (int j = 1; j <= 400 && !fin; j++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      rx = (j == force_j) ? force_val : tx;
      sp = 1'b1;
      @(negedge clk);
      sp = 1'b0;
      rx = 1'b1;
      if (done) begin n_done++; fin = 1'b1; end
      else if (arb_lost) begin n_arb++; fin = 1'b1; end
      else obs_q.push_back(tx);
    end
    tests_run++;
    if (fin !== 1'b1) begin
      tests_failed++;
      $display("FAIL stream_timeout: no done/arb_lost within 400 SP strobes");
    end
  endtask

  task automatic idle_sps(input int n);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      rx = tx;
      sp = 1'b1;
      @(negedge clk);
      sp = 1'b0;
      tests_run++;
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
        tests_failed++;
        $display("FAIL idle_sp: tx=%b busy=%b done=%b expected 1/0/0", tx, busy, done);
      end
    end
  endtask

  task automatic check_stream(input string name);
    bit ok;
    ok = (obs_q.size() == exp_q.size());
    for (int i = 0; ok && i < exp_q.size(); i++) if (obs_q[i] !== exp_q[i]) ok = 1'b0;
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL %s_stream: got %0d bits, expected %0d bits (or bit values differ)",
               name, obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || arb_lost !== 1'b0 || ack_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_values: tx=%b busy=%b done=%b arb=%b ack_err=%b expected 1/0/0/0/0",
               tx, busy, done, arb_lost, ack_err);
    end
    rst_n = 1'b1;
    idle_sps(2);
  endtask

  task automatic test_base_zero();
    int nd, na;
    bit [5:0] head;
    build_model(1'b0, 1'b0, 11'h000, 18'h0, 4'd0, 64'h0);
    launch(1'b0, 1'b0, 11'h000, 18'h0, 4'd0, 64'h0);
    run_stream(0, 1'b0, nd, na);
    for (int i = 0; i < 6; i++) head[5 - i] = (i < obs_q.size()) ? obs_q[i] : 1'bx;
    tests_run++;
    if (head !== 6'b000001) begin
      tests_failed++;
      $display("FAIL zero_head: first 6 bits=%b expected 000001", head);
    end
    tests_run++;
    if (obs_q.size() != 47 + exp_stuffs) begin
      tests_failed++;
      $display("FAIL zero_length: %0d bits, expected %0d", obs_q.size(), 47 + exp_stuffs);
    end
    check_stream("zero");
    tests_run++;
    if (nd != 1 || busy !== 1'b0 || tx !== 1'b1) begin
      tests_failed++;
      $display("FAIL zero_done: done_count=%0d busy=%b tx=%b expected 1/0/1", nd, busy, tx);
    end
    tests_run++;
    if (ack_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL zero_ack_err: ack_err=%b expected 1", ack_err);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_done_width: done=%b one cycle later, expected 0", done);
    end
  endtask

  task automatic test_base_data();
    int nd, na;
    bit [14:0] got_crc;
    bit ok;
    build_model(1'b0, 1'b0, 11'h123, 18'h0, 4'd1, 64'hAA00_0000_0000_0000);
    launch(1'b0, 1'b0, 11'h123, 18'h0, 4'd1, 64'hAA00_0000_0000_0000);
    run_stream(exp_ack_idx + 2, 1'b0, nd, na);
    destuff(unst_q.size());
    got_crc = 'x;
    if (dq.size() == unst_q.size())
      for (int i = 0; i < 15; i++) got_crc[14 - i] = dq[dq.size() - 15 + i];
    tests_run++;
    if (got_crc !== exp_crc) begin
      tests_failed++;
      $display("FAIL data_crc: got %h expected %h", got_crc, exp_crc);
    end
    ok = (dq.size() == unst_q.size());
    for (int i = 0; ok && i < unst_q.size(); i++) if (dq[i] !== unst_q[i]) ok = 1'b0;
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL data_destuffed: %0d bits recovered, expected %0d (or values differ)",
               dq.size(), unst_q.size());
    end
    check_stream("data");
    tests_run++;
    if (ack_err !== 1'b0 || nd != 1) begin
      tests_failed++;
      $display("FAIL data_ack: ack_err=%b done_count=%0d expected 0/1", ack_err, nd);
    end
  endtask

  task automatic test_ext_rtr();
    int nd, na;
    build_model(1'b1, 1'b1, 11'h7FF, 18'h3FFFF, 4'd4, 64'hDEAD_BEEF_0123_4567);
    launch(1'b1, 1'b1, 11'h7FF, 18'h3FFFF, 4'd4, 64'hDEAD_BEEF_0123_4567);
    run_stream(exp_ack_idx + 2, 1'b0, nd, na);
    destuff(54);
    tests_run++;
    if (dq.size() != 54 || dq[12] !== 1'b1 || dq[13] !== 1'b1) begin
      tests_failed++;
      $display("FAIL ext_srr_ide: recovered=%0d srr=%b ide=%b expected 54/1/1",
               dq.size(), (dq.size() > 12) ? dq[12] : 1'bx, (dq.size() > 13) ? dq[13] : 1'bx);
    end
    tests_run++;
    if (obs_q.size() != 54 + exp_stuffs + 13) begin
      tests_failed++;
      $display("FAIL ext_no_data: %0d bits, expected %0d", obs_q.size(), 54 + exp_stuffs + 13);
    end
    check_stream("ext");
    tests_run++;
    if (nd != 1 || ack_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL ext_done: done_count=%0d ack_err=%b expected 1/0", nd, ack_err);
    end
  endtask

  task automatic test_random_frames();
    int nd, na;
    bit r_ide, r_rtr;
    bit [10:0] r_id;
    bit [17:0] r_idex;
    bit [3:0] r_dlc;
    bit [63:0] r_data;
    for (int k = 0; k < 4; k++) begin
      r_ide = 1'($urandom);
      r_rtr = 1'($urandom_range(0, 3) == 0);
      r_id = 11'($urandom);
      r_idex = 18'($urandom);
      r_dlc = 4'($urandom);
      r_data = {$urandom, $urandom};
      build_model(r_ide, r_rtr, r_id, r_idex, r_dlc, r_data);
      launch(r_ide, r_rtr, r_id, r_idex, r_dlc, r_data);
      run_stream(exp_ack_idx + 2, 1'b0, nd, na);
      check_stream("random");
      tests_run++;
      if (nd != 1 || ack_err !== 1'b0) begin
        tests_failed++;
        $display("FAIL random_done: frame %0d done_count=%0d ack_err=%b expected 1/0", k, nd, ack_err);
      end
    end
  endtask

  task automatic test_arbitration();
    int nd, na;
    build_model(1'b0, 1'b0, 11'h400, 18'h0, 4'd2, 64'h1234_0000_0000_0000);
    launch(1'b0, 1'b0, 11'h400, 18'h0, 4'd2, 64'h1234_0000_0000_0000);
    run_stream(3, 1'b0, nd, na);
`ifdef CAN_TX_ARB_MON_EN
    tests_run++;
    if (na != 1 || nd != 0 || obs_q.size() != 2) begin
      tests_failed++;
      $display("FAIL arb_lost_pulse: arb=%0d done=%0d bits=%0d expected 1/0/2", na, nd, obs_q.size());
    end
    tests_run++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL arb_release: tx=%b busy=%b expected 1/0", tx, busy);
    end
    @(negedge clk);
    tests_run++;
    if (arb_lost !== 1'b0) begin
      tests_failed++;
      $display("FAIL arb_pulse_width: arb_lost=%b one cycle later, expected 0", arb_lost);
    end
`else
    tests_run++;
    if (na != 0 || nd != 1) begin
      tests_failed++;
      $display("FAIL arb_ignored: arb=%0d done=%0d expected 0/1", na, nd);
    end
    check_stream("arb_off");
    tests_run++;
    if (arb_lost !== 1'b0 || ack_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL arb_off_flags: arb_lost=%b ack_err=%b expected 0/1", arb_lost, ack_err);
    end
`endif
  endtask

  task automatic test_reset_and_start();
    int nd, na;
    launch(1'b0, 1'b0, 11'h2A5, 18'h0, 4'd8, {$urandom, $urandom});
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      rx = tx;
      sp = 1'b1;
      @(negedge clk);
      sp = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset: tx=%b busy=%b expected 1/0", tx, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // start coinciding with SP: SOF must wait for the next strobe
    build_model(1'b0, 1'b0, 11'h555, 18'h0, 4'd3, 64'hC3A5_0F00_0000_0000);
    @(negedge clk);
    ide = 1'b0; rtr = 1'b0; idf = 11'h555; idf_ex = '0; dlc = 4'd3;
    data = 64'hC3A5_0F00_0000_0000;
    start = 1'b1;
    sp = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sp = 1'b0;
    tests_run++;
    if (tx !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL start_with_sp: tx=%b busy=%b expected 1/1", tx, busy);
    end
    // start while busy with a different descriptor: must be ignored
    @(negedge clk);
    idf = 11'h0F0; dlc = 4'd8; data = '1; ide = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_stream(exp_ack_idx + 2, 1'b0, nd, na);
    check_stream("busy_start");
    tests_run++;
    if (nd != 1) begin
      tests_failed++;
      $display("FAIL busy_start_done: done_count=%0d expected 1", nd);
    end
    idle_sps(4);
  endtask

  initial begin
    test_reset();
    test_base_zero();
    test_base_data();
    test_ext_rtr();
    test_random_frames();
    test_arbitration();
    test_reset_and_start();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
